ex_mem: RTL and testbench
=========================

EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 The block SHALL have parameter REGS_ADDR_W, default 5, meaning register-address width; it SHALL equal the `REGS_ADDR_BUS width.
REQ-002 The block SHALL have parameter REGS_DATA_W, default 32, meaning register-data width; it SHALL equal the `REGS_DATA_BUS width.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset (`ENABLE = asserted).
REQ-005 The block SHALL have port stall_current, input, 1, meaning the EX stage is stalled this cycle.
REQ-006 The block SHALL have port stall_next, input, 1, meaning the MEM stage is stalled this cycle.
REQ-007 The block SHALL have port flush, input, 1, meaning discard the in-flight instruction (exception/redirect).
REQ-008 The block SHALL have ports ex_write_enable (input, 1), ex_write_addr (input, `REGS_ADDR_BUS) and ex_write_data (input, `REGS_DATA_BUS), carrying the EX general-register writeback request.
REQ-009 The block SHALL have ports ex_hilo_write_enable (input, 1), ex_hi (input, 32) and ex_lo (input, 32), carrying the EX HI/LO writeback request.
REQ-010 The block SHALL have ports ex_hilo_temp (input, 64) and ex_cycle_count (input, 2), carrying EX multicycle (madd/msub) partial state.
REQ-011 The block SHALL have ports write_enable (output, 1), write_addr (output, `REGS_ADDR_BUS) and write_data (output, `REGS_DATA_BUS), registered to the MEM stage.
REQ-012 The block SHALL have ports hilo_write_enable (output, 1), hi (output, 32) and lo (output, 32), registered to the MEM stage.
REQ-013 The block SHALL have ports hilo_temp (output, 64) and cycle_count (output, 2), registered and fed back to EX.
REQ-014 The block SHALL have port bubble_count, output, 32, counting bubbles inserted into MEM.

Function
REQ-015 The block SHALL give exactly one cycle of latency: values sampled at edge N SHALL be visible after edge N.
REQ-016 The block SHALL evaluate four modes per edge in this priority: FLUSH, BUBBLE, HOLD, ADVANCE.
REQ-017 FLUSH (flush=1): every output except bubble_count SHALL be cleared to 0, and write_enable and hilo_write_enable SHALL be `DISABLE, regardless of the stall inputs.
REQ-018 BUBBLE (stall_current=1, stall_next=0): all MEM-facing outputs SHALL be cleared to 0 (write_enable and hilo_write_enable `DISABLE), hilo_temp SHALL load ex_hilo_temp, and cycle_count SHALL load ex_cycle_count.
REQ-019 HOLD (stall_current=1, stall_next=1): every output SHALL keep its value.
REQ-020 ADVANCE (stall_current=0): every MEM-facing output SHALL load its ex_* counterpart, and hilo_temp and cycle_count SHALL clear to 0.
REQ-021 stall_current=0 with stall_next=1 SHALL be treated as ADVANCE; the upstream stall controller guarantees it does not occur.
REQ-022 bubble_count SHALL increment by 1 in BUBBLE mode only and SHALL saturate at 32'hFFFF_FFFF with no wrap.
REQ-023 bubble_count SHALL be unaffected by flush.
REQ-024 No output SHALL depend combinationally on any input.

Reset
REQ-025 Assertion of reset SHALL immediately, without waiting for a clock edge, set every output to 0 (enables `DISABLE), including bubble_count.
REQ-026 Reset asserted mid-multicycle SHALL discard hilo_temp and cycle_count, and the next instruction SHALL start clean.
REQ-027 On the first rising edge after reset deassertion the block SHALL follow normal mode priority.

Structure
REQ-028 `ENABLE, `DISABLE, `REGS_ADDR_BUS, `REGS_DATA_BUS, `DOUBLE_REGS_BUS (64-bit) and `CYCLE_COUNT_BUS (2-bit) SHALL live in the shared utility.v header.
REQ-029 A single sub-module, stage_reg, SHALL be used: a width-parameterised flop with async reset plus hold and clear controls, instantiated per field group.
REQ-030 bubble_count logic SHALL stay in ex_mem itself.

Verification
REQ-031 The bench SHALL cover: ADVANCE with ex_write_enable=1, addr=5'd3, data=32'hDEADBEEF -> after 1 edge write_enable=1, write_addr=3, write_data=32'hDEADBEEF, hilo_temp=0.
REQ-032 The bench SHALL cover: BUBBLE with ex_hilo_temp=64'h1_0000_0002, ex_cycle_count=2'd1 -> write_enable=0, write_data=0, hilo_temp=64'h1_0000_0002, cycle_count=1, bubble_count +1.
REQ-033 The bench SHALL cover: HOLD for 3 edges after an ADVANCE of data 32'h12345678 while ex_* inputs change -> outputs stay 32'h12345678 and bubble_count is unchanged.
REQ-034 The bench SHALL cover: flush=1 together with stall_current=1 and stall_next=0 -> all outputs 0 and bubble_count unchanged.
REQ-035 The bench SHALL cover: bubble_count preloaded to 32'hFFFF_FFFE followed by 3 BUBBLE edges -> bubble_count ends at 32'hFFFF_FFFF.
REQ-036 The bench SHALL cover: reset pulsed between clock edges while hi=32'hA5A5A5A5 -> hi=0 before the next edge, and all outputs 0.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg -- shared pipeline definitions for the EX/MEM stage register.
// Holds the common utility macros (enable levels and bus ranges) used by
// the pipeline files, the stage-register mode encoding and the mode
// decoder. No ports; compiled ahead of every file that imports it.

`ifndef UTILITY_V
`define UTILITY_V
`define ENABLE          1'b1
`define DISABLE         1'b0
`define REGS_ADDR_BUS   4:0
`define REGS_DATA_BUS   31:0
`define DOUBLE_REGS_BUS 63:0
`define CYCLE_COUNT_BUS 1:0
`endif

package ex_mem_pkg;

  localparam int          REGS_ADDR_W_DEF = 5;
  localparam int          REGS_DATA_W_DEF = 32;
  localparam int          BUBBLE_CNT_W    = 32;
  localparam logic [31:0] BUBBLE_MAX      = 32'hFFFF_FFFF;

  // Per-edge behaviour of the EX/MEM register.
  typedef enum logic [1:0] {
    MODE_ADVANCE = 2'd0,
    MODE_HOLD    = 2'd1,
    MODE_BUBBLE  = 2'd2,
    MODE_FLUSH   = 2'd3
  } ex_mem_mode_e;

  // Priority: flush, then bubble (EX stalled, MEM free), then hold.
  // EX running with MEM stalled cannot occur upstream and falls to ADVANCE.
  function automatic ex_mem_mode_e decode_mode(input logic flush,
                                               input logic stall_current,
                                               input logic stall_next);
    if (flush)                            return MODE_FLUSH;
    else if (stall_current && !stall_next) return MODE_BUBBLE;
    else if (stall_current)                return MODE_HOLD;
    else                                   return MODE_ADVANCE;
  endfunction

endpackage

// File: rtl/ex_mem_stage_reg.sv
// stage_reg -- width-parameterised pipeline flop group.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   hold         : keep the current value
//   clear        : load zero (wins over hold)
//   d / q        : W-bit data in / registered data out

module stage_reg #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         hold,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      q <= '0;
    else if (clear) q <= '0;
    else if (!hold) q <= d;
  end

endmodule

// File: rtl/ex_mem.sv
// ex_mem -- EX/MEM pipeline register with flush, bubble and hold handling.
// Ports:
//   clock, reset            : rising-edge clock, async active-high reset
//   stall_current/next      : EX / MEM stage stall requests
//   flush                   : discard the in-flight instruction
//   ex_write_*              : GPR writeback request from EX
//   ex_hilo_write_enable,
//   ex_hi, ex_lo            : HI/LO writeback request from EX
//   ex_hilo_temp,
//   ex_cycle_count          : madd/msub partial state from EX
//   write_*, hilo_*, hi, lo : registered copies towards MEM
//   hilo_temp, cycle_count  : registered partial state fed back to EX
//   bubble_count            : saturating count of bubbles sent to MEM

module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int REGS_ADDR_W = REGS_ADDR_W_DEF,
  parameter int REGS_DATA_W = REGS_DATA_W_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall_current,
  input  logic                    stall_next,
  input  logic                    flush,
  input  logic                    ex_write_enable,
  input  logic [REGS_ADDR_W-1:0]  ex_write_addr,
  input  logic [REGS_DATA_W-1:0]  ex_write_data,
  input  logic                    ex_hilo_write_enable,
  input  logic [31:0]             ex_hi,
  input  logic [31:0]             ex_lo,
  input  logic [`DOUBLE_REGS_BUS] ex_hilo_temp,
  input  logic [`CYCLE_COUNT_BUS] ex_cycle_count,
  output logic                    write_enable,
  output logic [REGS_ADDR_W-1:0]  write_addr,
  output logic [REGS_DATA_W-1:0]  write_data,
  output logic                    hilo_write_enable,
  output logic [31:0]             hi,
  output logic [31:0]             lo,
  output logic [`DOUBLE_REGS_BUS] hilo_temp,
  output logic [`CYCLE_COUNT_BUS] cycle_count,
  output logic [BUBBLE_CNT_W-1:0] bubble_count
);

  localparam int GPR_W  = 1 + REGS_ADDR_W + REGS_DATA_W;
  localparam int HILO_W = 1 + 32 + 32;
  localparam int MC_W   = 64 + 2;

  ex_mem_mode_e mode;
  logic         hold_all;
  logic         mem_clear;
  logic         fb_clear;

  logic [GPR_W-1:0]  gpr_d,  gpr_q;
  logic [HILO_W-1:0] hilo_d, hilo_q;
  logic [MC_W-1:0]   mc_d,   mc_q;

  assign mode     = decode_mode(flush, stall_current, stall_next);
  assign hold_all = (mode == MODE_HOLD);
  // MEM-facing fields go to zero on a flush or when a bubble is injected.
  assign mem_clear = (mode == MODE_FLUSH) || (mode == MODE_BUBBLE);
  // The multicycle partial state only survives while EX is stalled on it.
  assign fb_clear  = (mode == MODE_FLUSH) || (mode == MODE_ADVANCE);

  assign gpr_d  = {ex_write_enable, ex_write_addr, ex_write_data};
  assign hilo_d = {ex_hilo_write_enable, ex_hi, ex_lo};
  assign mc_d   = {ex_hilo_temp, ex_cycle_count};

  stage_reg #(.W(GPR_W)) u_gpr (
    .clock (clock),
    .reset (reset),
    .hold  (hold_all),
    .clear (mem_clear),
    .d     (gpr_d),
    .q     (gpr_q)
  );

  stage_reg #(.W(HILO_W)) u_hilo (
    .clock (clock),
    .reset (reset),
    .hold  (hold_all),
    .clear (mem_clear),
    .d     (hilo_d),
    .q     (hilo_q)
  );

  stage_reg #(.W(MC_W)) u_mc (
    .clock (clock),
    .reset (reset),
    .hold  (hold_all),
    .clear (fb_clear),
    .d     (mc_d),
    .q     (mc_q)
  );

  assign {write_enable, write_addr, write_data} = gpr_q;
  assign {hilo_write_enable, hi, lo}            = hilo_q;
  assign {hilo_temp, cycle_count}               = mc_q;

  // Flush outranks bubble in the mode decode, so a flushed edge never counts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      bubble_count <= '0;
    else if (mode == MODE_BUBBLE && bubble_count != BUBBLE_MAX)
      bubble_count <= bubble_count + 32'd1;
  end

endmodule

// File: tb/tb_ex_mem.sv
module tb_ex_mem;

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        hwe;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] ht;
    logic [1:0]  cc;
    logic [31:0] bc;
  } snap_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall_current, stall_next, flush;
  logic        ex_write_enable;
  logic [4:0]  ex_write_addr;
  logic [31:0] ex_write_data;
  logic        ex_hilo_write_enable;
  logic [31:0] ex_hi, ex_lo;
  logic [63:0] ex_hilo_temp;
  logic [1:0]  ex_cycle_count;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        hilo_write_enable;
  logic [31:0] hi, lo;
  logic [63:0] hilo_temp;
  logic [1:0]  cycle_count;
  logic [31:0] bubble_count;

  snap_t       sb_q[$];
  snap_t       obs, exp_s;
  logic [31:0] exp_bc;
  int          n_cmp = 0;
  int          n_err = 0;

  ex_mem dut (
    .clock                (clock),
    .reset                (reset),
    .stall_current        (stall_current),
    .stall_next           (stall_next),
    .flush                (flush),
    .ex_write_enable      (ex_write_enable),
    .ex_write_addr        (ex_write_addr),
    .ex_write_data        (ex_write_data),
    .ex_hilo_write_enable (ex_hilo_write_enable),
    .ex_hi                (ex_hi),
    .ex_lo                (ex_lo),
    .ex_hilo_temp         (ex_hilo_temp),
    .ex_cycle_count       (ex_cycle_count),
    .write_enable         (write_enable),
    .write_addr           (write_addr),
    .write_data           (write_data),
    .hilo_write_enable    (hilo_write_enable),
    .hi                   (hi),
    .lo                   (lo),
    .hilo_temp            (hilo_temp),
    .cycle_count          (cycle_count),
    .bubble_count         (bubble_count)
  );

  always #5 clock = ~clock;

  function automatic snap_t sample();
    return {write_enable, write_addr, write_data, hilo_write_enable,
            hi, lo, hilo_temp, cycle_count, bubble_count};
  endfunction

  // Reference behaviour of one ADVANCE edge given the current ex_* inputs.
  function automatic snap_t exp_advance();
    return {ex_write_enable, ex_write_addr, ex_write_data, ex_hilo_write_enable,
            ex_hi, ex_lo, 64'd0, 2'd0, exp_bc};
  endfunction

  // Reference behaviour of one BUBBLE edge (exp_bc already updated).
  function automatic snap_t exp_bubble();
    return {1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0,
            ex_hilo_temp, ex_cycle_count, exp_bc};
  endfunction

  task automatic set_ex(input logic we, input logic [4:0] a, input logic [31:0] d,
                        input logic hwe, input logic [31:0] h, input logic [31:0] l,
                        input logic [63:0] ht, input logic [1:0] cc);
    ex_write_enable      = we;
    ex_write_addr        = a;
    ex_write_data        = d;
    ex_hilo_write_enable = hwe;
    ex_hi                = h;
    ex_lo                = l;
    ex_hilo_temp         = ht;
    ex_cycle_count       = cc;
  endtask

  task automatic set_ctl(input logic f, input logic sc, input logic sn);
    flush         = f;
    stall_current = sc;
    stall_next    = sn;
  endtask

  task automatic bump_bc();
    if (exp_bc != 32'hFFFF_FFFF) exp_bc = exp_bc + 32'd1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_ctl(1'b0, 1'b0, 1'b0);
    set_ex(1'b1, 5'd7, 32'h1111_2222, 1'b1, 32'h3, 32'h4, 64'h55, 2'd2);
    exp_bc = 32'd0;
    #1;
    obs = sample();
    n_cmp++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL reset_state: got %h want 0", obs);
    end
    @(negedge clock);
    obs = sample();
    n_cmp++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL reset_held_edge: got %h want 0", obs);
    end
    reset = 1'b0;
  endtask

  task automatic test_advance();
    for (int i = 0; i < 5; i++) begin
      if (i == 0)
        set_ex(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 64'hFFFF_0000_1234_5678, 2'd3);
      else
        set_ex(1'($urandom), 5'($urandom), $urandom, 1'($urandom), $urandom, $urandom,
               {$urandom, $urandom}, 2'($urandom));
      // stall_next alone still advances
      set_ctl(1'b0, 1'b0, (i == 3));
      sb_q.push_back(exp_advance());
      @(negedge clock);
      obs = sample();
      exp_s = sb_q.pop_front();
      n_cmp++;
      if (obs !== exp_s) begin
        n_err++;
        $display("FAIL advance[%0d]: got %h want %h", i, obs, exp_s);
      end
    end
  endtask

  task automatic test_bubble();
    set_ex(1'b1, 5'd9, 32'hCAFE_F00D, 1'b1, 32'h77, 32'h88, 64'h1_0000_0002, 2'd1);
    set_ctl(1'b0, 1'b1, 1'b0);
    bump_bc();
    sb_q.push_back(exp_bubble());
    @(negedge clock);
    obs = sample();
    exp_s = sb_q.pop_front();
    n_cmp++;
    if (obs !== exp_s) begin
      n_err++;
      $display("FAIL bubble: got %h want %h", obs, exp_s);
    end
    // second bubble edge in a row with new partial state
    set_ex(1'b1, 5'd1, 32'h1, 1'b1, 32'h2, 32'h3, 64'hABCD_0000_0000_0099, 2'd2);
    bump_bc();
    sb_q.push_back(exp_bubble());
    @(negedge clock);
    obs = sample();
    exp_s = sb_q.pop_front();
    n_cmp++;
    if (obs !== exp_s) begin
      n_err++;
      $display("FAIL bubble_b2b: got %h want %h", obs, exp_s);
    end
  endtask

  task automatic test_hold();
    snap_t held;
    set_ex(1'b1, 5'd17, 32'h12345678, 1'b1, 32'hA0A0_0001, 32'hB0B0_0002, 64'h9, 2'd1);
    set_ctl(1'b0, 1'b0, 1'b0);
    held = exp_advance();
    sb_q.push_back(held);
    @(negedge clock);
    obs = sample();
    exp_s = sb_q.pop_front();
    n_cmp++;
    if (obs !== exp_s) begin
      n_err++;
      $display("FAIL hold_setup: got %h want %h", obs, exp_s);
    end
    set_ctl(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      set_ex(1'($urandom), 5'($urandom), $urandom | 32'h1, 1'($urandom), $urandom,
             $urandom, {$urandom, $urandom} | 64'h1, 2'($urandom));
      sb_q.push_back(held);
      @(negedge clock);
      obs = sample();
      exp_s = sb_q.pop_front();
      n_cmp++;
      if (obs !== exp_s) begin
        n_err++;
        $display("FAIL hold[%0d]: got %h want %h", i, obs, exp_s);
      end
    end
  endtask

  task automatic test_flush();
    // load partial state so the flush has something to discard
    set_ex(1'b1, 5'd4, 32'h4444, 1'b1, 32'h5, 32'h6, 64'h7777_0000_0000_0001, 2'd3);
    set_ctl(1'b0, 1'b1, 1'b0);
    bump_bc();
    sb_q.push_back(exp_bubble());
    @(negedge clock);
    obs = sample();
    exp_s = sb_q.pop_front();
    n_cmp++;
    if (obs !== exp_s) begin
      n_err++;
      $display("FAIL flush_setup: got %h want %h", obs, exp_s);
    end
    set_ctl(1'b1, 1'b1, 1'b0);
    sb_q.push_back({169'd0, exp_bc});
    @(negedge clock);
    obs = sample();
    exp_s = sb_q.pop_front();
    n_cmp++;
    if (obs !== exp_s) begin
      n_err++;
      $display("FAIL flush_over_bubble: got %h want %h", obs, exp_s);
    end
    // flush also wins over hold, after some live data
    set_ctl(1'b0, 1'b0, 1'b0);
    set_ex(1'b1, 5'd30, 32'hFEED_0001, 1'b1, 32'h1234, 32'h5678, 64'h1, 2'd1);
    @(negedge clock);
    set_ctl(1'b1, 1'b1, 1'b1);
    sb_q.push_back({169'd0, exp_bc});
    @(negedge clock);
    obs = sample();
    exp_s = sb_q.pop_front();
    n_cmp++;
    if (obs !== exp_s) begin
      n_err++;
      $display("FAIL flush_over_hold: got %h want %h", obs, exp_s);
    end
  endtask

  task automatic test_saturate();
    force dut.bubble_count = 32'hFFFF_FFFE;
    #1;
    release dut.bubble_count;
    exp_bc = 32'hFFFF_FFFE;
    set_ctl(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set_ex(1'b1, 5'd2, 32'h2, 1'b0, 32'h0, 32'h0, 64'(i + 10), 2'(i));
      bump_bc();
      sb_q.push_back(exp_bubble());
      @(negedge clock);
      obs = sample();
      exp_s = sb_q.pop_front();
      n_cmp++;
      if (obs !== exp_s) begin
        n_err++;
        $display("FAIL saturate[%0d]: got %h want %h", i, obs, exp_s);
      end
    end
  endtask

  task automatic test_async_reset();
    set_ctl(1'b0, 1'b0, 1'b0);
    set_ex(1'b1, 5'd12, 32'h0BAD_CAFE, 1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A, 64'h0, 2'd0);
    sb_q.push_back(exp_advance());
    @(negedge clock);
    obs = sample();
    exp_s = sb_q.pop_front();
    n_cmp++;
    if (obs !== exp_s) begin
      n_err++;
      $display("FAIL pre_reset: got %h want %h", obs, exp_s);
    end
    #2 reset = 1'b1;
    #1;
    obs = sample();
    n_cmp++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL async_reset: got %h want 0 (hi=%h)", obs, hi);
    end
    #1 reset = 1'b0;
    exp_bc = 32'd0;
    // multicycle partial state, then reset between edges
    @(negedge clock);
    set_ctl(1'b0, 1'b1, 1'b0);
    set_ex(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h3_0000_0004, 2'd2);
    bump_bc();
    sb_q.push_back(exp_bubble());
    @(negedge clock);
    obs = sample();
    exp_s = sb_q.pop_front();
    n_cmp++;
    if (obs !== exp_s) begin
      n_err++;
      $display("FAIL multicycle_load: got %h want %h", obs, exp_s);
    end
    #2 reset = 1'b1;
    #1;
    obs = sample();
    n_cmp++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL reset_mid_multicycle: got %h want 0", obs);
    end
    exp_bc = 32'd0;
    set_ctl(1'b0, 1'b0, 1'b0);
    set_ex(1'b1, 5'd6, 32'h600D_0001, 1'b0, 32'h0, 32'h0, 64'h3_0000_0004, 2'd2);
    #1 reset = 1'b0;
    sb_q.push_back(exp_advance());
    @(negedge clock);
    obs = sample();
    exp_s = sb_q.pop_front();
    n_cmp++;
    if (obs !== exp_s) begin
      n_err++;
      $display("FAIL first_after_reset: got %h want %h", obs, exp_s);
    end
  endtask

  initial begin
    test_reset();
    test_advance();
    test_bubble();
    test_hold();
    test_flush();
    test_saturate();
    test_async_reset();
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
